poci_master_arb: RTL and testbench
==================================

Name: poci_master_arb

Overview:
Two-requester POCI bus master: arbitrates between two local requesters (e.g. CPU data port and a debug/DMA port) and sequences the shared POCI master bus through the SETUP and ACCESS phases.
- Handles pready wait states, pslverr and an optional timeout.
- Its POCI-side outputs drive the POCI address decoder's master side directly.
- Returns a one-cycle response to the granted requester.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, maximum ACCESS cycles with pready low before forced termination; 0 disables the timeout; legal range 0..65535

Ports:
pclk  input  1  POCI clock; all logic on its rising edge
presetn  input  1  asynchronous active-low reset
rq_valid  input  [1:0]  request valid per requester; held until the matching rq_ack
rq_write  input  [1:0]  1 = write, 0 = read
rq_addr  input  [1:0][AW-1:0]  request address
rq_wdata  input  [1:0][DW-1:0]  write data
rq_ack  output  [1:0]  one-cycle pulse: request accepted, fields latched
rsp_valid  output  [1:0]  one-cycle pulse: transfer finished
rsp_rdata  output  DW  read data; 0 for writes and for errors
rsp_err  output  1  error flag; valid with rsp_valid
m_paddr  output  AW  POCI address
m_psel  output  1  POCI select
m_penable  output  1  POCI enable
m_pwrite  output  1  POCI direction
m_pwdata  output  DW  POCI write data
m_prdata  input  DW  POCI read data
m_pready  input  1  POCI ready
m_pslverr  input  1  POCI slave error

Behaviour:
- All outputs are registered.
- Reset (presetn low, asynchronous): state=IDLE; all outputs 0; RR pointer=0; timeout counter=0. Asserting reset mid-transfer drops m_psel/m_penable immediately. No rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: when any rq_valid bit is 1, grant g and latch addr/write/wdata into the m_* registers. Next state SETUP.
- Arbitration: with one requester valid, grant it. With both valid, grant the requester not granted last (RR pointer). After reset, requester 0 wins the first tie. The pointer updates on each grant.
- SETUP (1 cycle): m_psel=1, m_penable=0, rq_ack[g]=1. Next state ACCESS.
- ACCESS: m_psel=1, m_penable=1.
  - m_pready=1 sampled: capture rsp_rdata = read ? m_prdata : 0 and rsp_err = m_pslverr (rsp_rdata forced to 0 when m_pslverr=1). rsp_valid[g]=1 in the following cycle. Next state IDLE.
  - m_pready=0: increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, terminate: next state IDLE, m_psel/m_penable drop, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
- Latency:
  - Zero-wait transfer: request seen in cycle 0, ack in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - Each wait state adds 1 cycle.
- Back-to-back operation: the IDLE cycle that carries rsp_valid also arbitrates, so a pending request enters SETUP on the next cycle. Minimum transfer pitch is 3 cycles.
- m_paddr/m_pwrite/m_pwdata are stable from SETUP through the end of ACCESS and hold their last values in IDLE.
- The counter clears on entry to SETUP.
- The counter is 16 bits and saturates without wrapping.
- rq_valid sampled only in IDLE; changes in other states are ignored.
- rq_valid deasserted illegally before ack: a request already latched completes normally.
- rsp_valid is at most one-hot; rq_ack is at most one-hot.

Test Plan:
1. Req0 read addr 0x40001004, slave returns prdata 0xA5A5_0001 with pready=1 in the first ACCESS cycle. Required:
   - m_psel high cycles 1-2, m_penable high cycle 2.
   - rq_ack[0] in cycle 1.
   - rsp_valid[0] in cycle 3 with rdata 0xA5A5_0001, rsp_err=0.
2. Req0 and req1 both valid from reset, both writes, held after each ack. Required:
   - Grant order 0,1,0,1.
   - Each m_pwdata matches the granted requester.
   - Grants start 3 cycles apart.
3. Req1 write with pready low for 4 ACCESS cycles. Required:
   - ACCESS lasts 5 cycles.
   - Address and data stable throughout.
   - rsp_valid[1] 1 cycle after pready, rsp_rdata=0.
4. Read with pslverr=1 and pready=1, prdata 0xDEAD_BEEF. Required: rsp_err=1, rsp_rdata=0.
5. TIMEOUT=8, pready held 0. Required:
   - After 8 ACCESS cycles m_psel drops.
   - rsp_valid and rsp_err=1.
   - Next queued request proceeds normally.
6. presetn asserted low during ACCESS. Required:
   - m_psel/m_penable go to 0 without waiting for a clock edge.
   - No rsp_valid.
   - After release, req0 wins a tie.

Source files
------------

// File: rtl/poci_master_arb.sv
// poci_master_arb: two-requester POCI bus master.
// Round-robin arbitration between two local requesters. Drives the shared
// POCI bus through its SETUP and ACCESS phases. Handles wait states, slave
// errors and an optional wait-state timeout, and returns a one-cycle response
// to the granted requester.
// Ports:
//   pclk, presetn           clock, asynchronous active-low reset
//   rq_valid/write/addr/wdata  per-requester request (held until rq_ack)
//   rq_ack                  one-cycle pulse when a request is latched
//   rsp_valid/rdata/err     one-cycle completion response
//   m_paddr..m_pwdata       registered POCI master outputs
//   m_prdata/pready/pslverr POCI slave response inputs
module poci_master_arb #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [1:0]         rq_valid,
    input  logic [1:0]         rq_write,
    input  logic [1:0][AW-1:0] rq_addr,
    input  logic [1:0][DW-1:0] rq_wdata,
    output logic [1:0]         rq_ack,
    output logic [1:0]         rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic [AW-1:0]      m_paddr,
    output logic               m_psel,
    output logic               m_penable,
    output logic               m_pwrite,
    output logic [DW-1:0]      m_pwdata,
    input  logic [DW-1:0]      m_prdata,
    input  logic               m_pready,
    input  logic               m_pslverr
);

    localparam int unsigned   CW       = 16;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit            TO_EN    = (TIMEOUT != 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]    state, state_d;
    logic          gnt, gnt_d;       // requester owning the current transfer
    logic          prio, prio_d;     // requester that wins the next tie
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic          sel;

    logic [1:0]    rq_ack_d, rsp_valid_d;
    logic [DW-1:0] rsp_rdata_d, m_pwdata_d;
    logic          rsp_err_d, m_psel_d, m_penable_d, m_pwrite_d;
    logic [AW-1:0] m_paddr_d;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        gnt_d       = gnt;
        prio_d      = prio;
        cnt_d       = cnt;
        m_paddr_d   = m_paddr;
        m_pwrite_d  = m_pwrite;
        m_pwdata_d  = m_pwdata;
        m_psel_d    = m_psel;
        m_penable_d = m_penable;
        rq_ack_d    = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        sel         = 1'b0;
        // Saturating wait-state count
        cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

        case (state)
            S_IDLE: begin
                if (|rq_valid) begin
                    // Tie goes to prio; otherwise the lone valid requester
                    sel         = (rq_valid == 2'b11) ? prio : rq_valid[1];
                    gnt_d       = sel;
                    prio_d      = ~sel;
                    m_paddr_d   = rq_addr[sel];
                    m_pwrite_d  = rq_write[sel];
                    m_pwdata_d  = rq_wdata[sel];
                    m_psel_d    = 1'b1;
                    m_penable_d = 1'b0;
                    rq_ack_d[sel] = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_SETUP;
                end
            end
            S_SETUP: begin
                m_penable_d = 1'b1;
                state_d     = S_ACCESS;
            end
            S_ACCESS: begin
                if (m_pready) begin
                    m_psel_d         = 1'b0;
                    m_penable_d      = 1'b0;
                    rsp_valid_d[gnt] = 1'b1;
                    rsp_err_d        = m_pslverr;
                    rsp_rdata_d      = (!m_pwrite && !m_pslverr) ? m_prdata : '0;
                    state_d          = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (TO_EN && (cnt_inc == TO_LIMIT)) begin
                        // Forced termination reported as a slave error
                        m_psel_d         = 1'b0;
                        m_penable_d      = 1'b0;
                        rsp_valid_d[gnt] = 1'b1;
                        rsp_err_d        = 1'b1;
                        state_d          = S_IDLE;
                    end
                end
            end
            default: begin
                m_psel_d    = 1'b0;
                m_penable_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= S_IDLE;
            gnt       <= 1'b0;
            prio      <= 1'b0;
            cnt       <= '0;
            rq_ack    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            m_paddr   <= '0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_pwdata  <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            prio      <= prio_d;
            cnt       <= cnt_d;
            rq_ack    <= rq_ack_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            m_paddr   <= m_paddr_d;
            m_psel    <= m_psel_d;
            m_penable <= m_penable_d;
            m_pwrite  <= m_pwrite_d;
            m_pwdata  <= m_pwdata_d;
        end
    end

endmodule

// File: tb/tb_poci_master_arb.sv
// tb_poci_master_arb: directed bench for poci_master_arb with a
// transaction-level reference model compared every cycle, plus literal
// cycle-exact expectations for each scenario.
module tb_poci_master_arb;

    localparam int unsigned TO = 8;

    logic              pclk;
    logic              presetn;
    logic [1:0]        rq_valid;
    logic [1:0]        rq_write;
    logic [1:0][31:0]  rq_addr;
    logic [1:0][31:0]  rq_wdata;
    logic [1:0]        rq_ack;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       m_paddr;
    logic              m_psel;
    logic              m_penable;
    logic              m_pwrite;
    logic [31:0]       m_pwdata;
    logic [31:0]       m_prdata;
    logic              m_pready;
    logic              m_pslverr;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    poci_master_arb #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .rq_valid  (rq_valid),
        .rq_write  (rq_write),
        .rq_addr   (rq_addr),
        .rq_wdata  (rq_wdata),
        .rq_ack    (rq_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_paddr   (m_paddr),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record with its age on the bus
    // (1 = address phase, >=2 = data phase) and a wait-state tally.
    bit          md_busy  = 1'b0;
    int          md_who   = 0;
    int          md_age   = 0;
    int          md_waits = 0;
    bit          md_prio  = 1'b0;
    logic        md_write = 1'b0;
    logic [1:0]  e_ack = '0, e_rsp_valid = '0;
    logic [31:0] e_rdata = '0, e_paddr = '0, e_pwdata = '0;
    logic        e_err = 1'b0, e_pwrite = 1'b0, e_psel = 1'b0, e_penable = 1'b0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            md_busy = 1'b0; md_who = 0; md_age = 0; md_waits = 0; md_prio = 1'b0;
            md_write = 1'b0;
            e_ack = '0; e_rsp_valid = '0; e_rdata = '0; e_err = 1'b0;
            e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_psel = 1'b0; e_penable = 1'b0;
        end else begin
            e_ack = '0; e_rsp_valid = '0; e_rdata = '0; e_err = 1'b0;
            if (md_busy) begin
                if (md_age >= 2) begin
                    if (m_pready) begin
                        md_busy = 1'b0;
                        e_rsp_valid[md_who] = 1'b1;
                        e_err   = m_pslverr;
                        e_rdata = (!md_write && !m_pslverr) ? m_prdata : 32'h0;
                    end else begin
                        md_waits++;
                        if (TO != 0 && md_waits == int'(TO)) begin
                            md_busy = 1'b0;
                            e_rsp_valid[md_who] = 1'b1;
                            e_err = 1'b1;
                        end
                    end
                end
                if (md_busy) md_age++;
            end else if (rq_valid != 2'b00) begin
                md_who   = (rq_valid == 2'b11) ? int'(md_prio) : (rq_valid[1] ? 1 : 0);
                md_prio  = (md_who == 0);
                md_busy  = 1'b1;
                md_age   = 1;
                md_waits = 0;
                md_write = rq_write[md_who];
                e_paddr  = rq_addr[md_who];
                e_pwdata = rq_wdata[md_who];
                e_pwrite = rq_write[md_who];
                e_ack[md_who] = 1'b1;
            end
            e_psel    = md_busy;
            e_penable = md_busy && (md_age >= 2);
        end
    end

    // Per-cycle comparison against the model, plus an ack log
    int ack_who[$];
    int ack_cyc[$];

    always @(negedge pclk) begin
        chk("rq_ack",    64'(rq_ack),    64'(e_ack));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        chk("rsp_err",   64'(rsp_err),   64'(e_err));
        chk("m_paddr",   64'(m_paddr),   64'(e_paddr));
        chk("m_psel",    64'(m_psel),    64'(e_psel));
        chk("m_penable", 64'(m_penable), 64'(e_penable));
        chk("m_pwrite",  64'(m_pwrite),  64'(e_pwrite));
        chk("m_pwdata",  64'(m_pwdata),  64'(e_pwdata));
        if (rq_ack != 2'b00) begin
            ack_who.push_back(rq_ack[1] ? 1 : 0);
            ack_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        #2 presetn = 1'b1;
    endtask

    int n;
    int acc;

    initial begin
        presetn = 1'b0;
        rq_valid = '0; rq_write = '0; rq_addr = '0; rq_wdata = '0;
        m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
        do_reset();
        chk("reset_psel",  64'(m_psel),    64'h0);
        chk("reset_ack",   64'(rq_ack),    64'h0);
        chk("reset_rsp",   64'(rsp_valid), 64'h0);

        // 1: zero-wait read from requester 0
        rq_valid = 2'b01; rq_write = 2'b00; rq_addr[0] = 32'h4000_1004;
        m_pready = 1'b1; m_prdata = 32'hA5A5_0001;
        tick();
        chk("t1_ack_c1",     64'(rq_ack),    64'h1);
        chk("t1_psel_c1",    64'(m_psel),    64'h1);
        chk("t1_penable_c1", 64'(m_penable), 64'h0);
        rq_valid = 2'b00;
        tick();
        chk("t1_psel_c2",    64'(m_psel),    64'h1);
        chk("t1_penable_c2", 64'(m_penable), 64'h1);
        tick();
        chk("t1_rsp_c3",   64'(rsp_valid), 64'h1);
        chk("t1_rdata_c3", 64'(rsp_rdata), 64'hA5A5_0001);
        chk("t1_err_c3",   64'(rsp_err),   64'h0);
        chk("t1_psel_c3",  64'(m_psel),    64'h0);

        // 2: both requesters hold writes from reset; round-robin
        rq_valid = 2'b11; rq_write = 2'b11;
        rq_addr[0] = 32'h4000_0100; rq_addr[1] = 32'h4000_0200;
        rq_wdata[0] = 32'h1111_0000; rq_wdata[1] = 32'h2222_0000;
        presetn = 1'b0;
        repeat (2) @(posedge pclk);
        ack_who.delete(); ack_cyc.delete();
        #2 presetn = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 4; i++) begin
            tick();
            if (rq_ack != 2'b00) begin
                chk("t2_pwdata", 64'(m_pwdata), (n % 2 == 0) ? 64'h1111_0000 : 64'h2222_0000);
                n++;
            end
        end
        rq_valid = 2'b00;
        chk("t2_grants", 64'(n), 64'd4);
        repeat (3) tick();
        chk("t2_log_size", 64'(ack_who.size()), 64'd4);
        if (ack_who.size() >= 4) begin
            chk("t2_order0", 64'(ack_who[0]), 64'd0);
            chk("t2_order1", 64'(ack_who[1]), 64'd1);
            chk("t2_order2", 64'(ack_who[2]), 64'd0);
            chk("t2_order3", 64'(ack_who[3]), 64'd1);
            for (int i = 0; i < 3; i++)
                chk("t2_pitch", 64'(ack_cyc[i+1] - ack_cyc[i]), 64'd3);
        end

        // 3: requester 1 write, four wait states
        rq_valid = 2'b10; rq_write = 2'b10; rq_addr[1] = 32'h4000_2008;
        rq_wdata[1] = 32'hCAFE_0003; m_pready = 1'b0; m_prdata = 32'h1234_5678;
        tick();
        chk("t3_ack", 64'(rq_ack), 64'h2);
        rq_valid = 2'b00;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_penable) acc++;
            chk("t3_paddr",  64'(m_paddr),  64'h4000_2008);
            chk("t3_pwdata", 64'(m_pwdata), 64'hCAFE_0003);
            if (i == 4) m_pready = 1'b1;
        end
        tick();
        chk("t3_access_len", 64'(acc),        64'd5);
        chk("t3_rsp",        64'(rsp_valid),  64'h2);
        chk("t3_rdata",      64'(rsp_rdata),  64'h0);
        chk("t3_penable",    64'(m_penable),  64'h0);

        // 4: read with slave error
        rq_valid = 2'b01; rq_write = 2'b00; rq_addr[0] = 32'h4000_3000;
        m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = 32'hDEAD_BEEF;
        tick();
        rq_valid = 2'b00;
        tick();
        tick();
        chk("t4_rsp",   64'(rsp_valid), 64'h1);
        chk("t4_err",   64'(rsp_err),   64'h1);
        chk("t4_rdata", 64'(rsp_rdata), 64'h0);
        m_pslverr = 1'b0;

        // 5: timeout, then a queued write from requester 1
        rq_valid = 2'b01; rq_write = 2'b00; rq_addr[0] = 32'h4000_4000;
        m_pready = 1'b0; m_prdata = 32'h0BAD_0BAD;
        tick();
        chk("t5_ack0", 64'(rq_ack), 64'h1);
        rq_valid = 2'b10; rq_write = 2'b10; rq_addr[1] = 32'h4000_5000;
        rq_wdata[1] = 32'h5555_AAAA;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_penable) acc++;
        end
        chk("t5_access_len", 64'(acc), 64'd8);
        tick();
        chk("t5_psel_drop", 64'(m_psel),    64'h0);
        chk("t5_rsp",       64'(rsp_valid), 64'h1);
        chk("t5_err",       64'(rsp_err),   64'h1);
        chk("t5_rdata",     64'(rsp_rdata), 64'h0);
        m_pready = 1'b1;
        tick();
        chk("t5_ack1", 64'(rq_ack), 64'h2);
        rq_valid = 2'b00;
        tick();
        tick();
        chk("t5_rsp1", 64'(rsp_valid), 64'h2);
        chk("t5_err1", 64'(rsp_err),   64'h0);

        // 6: reset during ACCESS, then a tie after release
        rq_valid = 2'b10; rq_write = 2'b00; rq_addr[1] = 32'h4000_6000;
        m_pready = 1'b0;
        tick();
        rq_valid = 2'b00;
        tick();
        chk("t6_penable_before", 64'(m_penable), 64'h1);
        #1 presetn = 1'b0;
        #1;
        chk("t6_psel_async",    64'(m_psel),    64'h0);
        chk("t6_penable_async", 64'(m_penable), 64'h0);
        chk("t6_no_rsp",        64'(rsp_valid), 64'h0);
        rq_valid = 2'b11; rq_write = 2'b00;
        rq_addr[0] = 32'h4000_7000; rq_addr[1] = 32'h4000_8000;
        m_pready = 1'b1; m_prdata = 32'h0000_7777;
        repeat (2) @(posedge pclk);
        #2 presetn = 1'b1;
        tick();
        chk("t6_tie_ack", 64'(rq_ack), 64'h1);
        rq_valid = 2'b00;
        tick();
        tick();
        chk("t6_rsp",   64'(rsp_valid), 64'h1);
        chk("t6_rdata", 64'(rsp_rdata), 64'h0000_7777);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
